// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the multiplier sequencer.
// State encoding, RSEL levels and counter sizing.
package mul_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LOAD_A = 4'd1,
      ST_LOAD_B = 4'd2,
      ST_GAP    = 4'd3,
      ST_PHI    = 4'd4,
      ST_PLO    = 4'd5,
      ST_RD_LO  = 4'd6,
      ST_RD_HI  = 4'd7,
      ST_DONE   = 4'd8
   } state_t;

   localparam logic RSEL_LO = 1'b0;
   localparam logic RSEL_HI = 1'b1;

   // Bits needed to hold the value n (0..n inclusive).
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Requester and multiplier-side signals of the sequencer.
// slave is the sequencer view; master is the surrounding system.
interface mul_seq_if;

   logic [1:0] REQ;
   logic [3:0] OPA0;
   logic [3:0] OPB0;
   logic [3:0] OPA1;
   logic [3:0] OPB1;
   logic [1:0] ACK;
   logic [7:0] PROD;
   logic       BUSY;
   logic [3:0] M_DIN;
   logic       M_LOAD;
   logic       M_RSEL;
   logic       M_CLK;
   logic [3:0] M_R;

   modport slave (
      input  REQ, OPA0, OPB0, OPA1, OPB1, M_R,
      output ACK, PROD, BUSY,
      output M_DIN, M_LOAD, M_RSEL, M_CLK
   );

   modport master (
      output REQ, OPA0, OPB0, OPA1, OPB1, M_R,
      input  ACK, PROD, BUSY,
      input  M_DIN, M_LOAD, M_RSEL, M_CLK
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant,
// pointer moves to the loser whenever take accepts a grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (take && (|gnt)) begin
         ptr <= gnt[0];
      end
   end

endmodule

// File: rtl/mul_seq.sv
// Sequencer for the 4x4 shift-add multiplier: arbitrates two
// requesters, drives load/step/readback, returns product + ACK.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int NPULSE = 4,
   parameter int HOLD   = 1
) (
   input logic   CLK,
   input logic   RST,
   mul_seq_if.slave bus
);

   localparam int PW = cnt_w(NPULSE);
   localparam int HW = cnt_w(HOLD);

   state_t      state;
   logic [1:0]  gnt;
   logic        take;
   logic        sel;
   logic [3:0]  b_q;
   logic [3:0]  lo_q;
   logic [PW-1:0] pcnt;
   logic [HW-1:0] hcnt;

   assign take = (state == ST_IDLE);

   rr_arb2 u_arb (
      .clk  (CLK),
      .rst  (RST),
      .req  (bus.REQ),
      .take (take),
      .gnt  (gnt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         sel        <= 1'b0;
         b_q        <= '0;
         lo_q       <= '0;
         pcnt       <= '0;
         hcnt       <= '0;
         bus.ACK    <= 2'b00;
         bus.PROD   <= '0;
         bus.BUSY   <= 1'b0;
         bus.M_DIN  <= '0;
         bus.M_LOAD <= 1'b0;
         bus.M_RSEL <= 1'b0;
         bus.M_CLK  <= 1'b0;
      end else begin
         bus.ACK <= 2'b00;
         unique case (state)
            ST_IDLE: begin
               if (|gnt) begin
                  sel        <= gnt[1];
                  b_q        <= gnt[1] ? bus.OPB1 : bus.OPB0;
                  bus.M_DIN  <= gnt[1] ? bus.OPA1 : bus.OPA0;
                  bus.M_LOAD <= 1'b1;
                  bus.M_RSEL <= RSEL_HI;
                  bus.BUSY   <= 1'b1;
                  state      <= ST_LOAD_A;
               end
            end
            ST_LOAD_A: begin
               bus.M_RSEL <= RSEL_LO;
               bus.M_DIN  <= b_q;
               state      <= ST_LOAD_B;
            end
            ST_LOAD_B: begin
               bus.M_LOAD <= 1'b0;
               bus.M_DIN  <= '0;
               state      <= ST_GAP;
            end
            // GAP keeps MUL_CLK low for a cycle after LOAD drops.
            ST_GAP: begin
               bus.M_CLK <= 1'b1;
               hcnt      <= HW'(HOLD - 1);
               pcnt      <= PW'(NPULSE);
               state     <= ST_PHI;
            end
            ST_PHI: begin
               if (hcnt == '0) begin
                  bus.M_CLK <= 1'b0;
                  hcnt      <= HW'(HOLD - 1);
                  state     <= ST_PLO;
               end else begin
                  hcnt <= hcnt - 1'b1;
               end
            end
            ST_PLO: begin
               if (hcnt == '0) begin
                  pcnt <= pcnt - 1'b1;
                  if (pcnt == PW'(1)) begin
                     bus.M_RSEL <= RSEL_LO;
                     state      <= ST_RD_LO;
                  end else begin
                     bus.M_CLK <= 1'b1;
                     hcnt      <= HW'(HOLD - 1);
                     state     <= ST_PHI;
                  end
               end else begin
                  hcnt <= hcnt - 1'b1;
               end
            end
            ST_RD_LO: begin
               lo_q       <= bus.M_R;
               bus.M_RSEL <= RSEL_HI;
               state      <= ST_RD_HI;
            end
            // PROD updates as a whole so it holds until completion.
            ST_RD_HI: begin
               bus.PROD   <= {bus.M_R, lo_q};
               bus.M_RSEL <= RSEL_LO;
               bus.ACK    <= sel ? 2'b10 : 2'b01;
               state      <= ST_DONE;
            end
            ST_DONE: begin
               bus.BUSY <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
